mul_job_seq: RTL and testbench

- Upstream/downstream wrapper for the shift-add multiplier top level (`top_view`).
- Accepts operand pairs from a host over a valid/ready handshake and drives the multiplier operand buses plus a one-cycle start pulse.
- Waits for done, then captures the 32-bit Z product into a 2-entry result buffer that drains over a second valid/ready handshake.
- Adds a zero-operand bypass and a watchdog timeout, so a hung multiplier cannot stall the host.

---
 rtl/mul_job_seq.sv | 129 ++++++++++++
 tb/tb_mul_job_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_job_seq.sv
// Job sequencer around the shift-add multiplier: accepts operand pairs, launches one
// multiply at a time, and queues products (or zero-bypass / watchdog results) in a 2-entry buffer.
module mul_job_seq #(
  parameter int WIDTH     = 32,
  parameter int TO_CYCLES = 200,
  parameter int TO_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             mul_start,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_to,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES - 1);

  state_t           state, state_nxt;
  logic [TO_W-1:0]  wd_cnt;
  logic [1:0]       count;
  logic [WIDTH-1:0] buf_z [2];
  logic             buf_to [2];
  logic             accept, bypass, wd_term, pop;
  logic             push, push_to;
  logic [WIDTH-1:0] push_z;

  assign accept  = in_valid && in_ready;
  assign bypass  = accept && ((in_a == '0) || (in_b == '0));
  assign wd_term = (wd_cnt == WD_LAST);
  assign pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !bypass) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (mul_done || wd_term) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done takes priority over the watchdog when both land in the same cycle
  always_comb begin
    in_ready  = (state == IDLE) && (count < 2'd2);
    mul_start = (state == START);
    busy      = (state != IDLE);
    push      = 1'b0;
    push_z    = '0;
    push_to   = 1'b0;
    case (state)
      IDLE: push = bypass;
      WAIT: begin
        if (mul_done) begin
          push   = 1'b1;
          push_z = mul_z;
        end else if (wd_term) begin
          push    = 1'b1;
          push_to = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // operands stay put for the whole multiply; only a new accept replaces them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (accept) begin
      op_a <= in_a;
      op_b <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 wd_cnt <= '0;
    else if (state == START)  wd_cnt <= '0;
    else if (state == WAIT)   wd_cnt <= wd_cnt + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= 2'd0;
    else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // slot 0 is the head; a push lands in slot 0 when it is (or is about to be) free
  always_ff @(posedge clk) begin
    if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
      buf_z[0]  <= push_z;
      buf_to[0] <= push_to;
    end else if (pop) begin
      buf_z[0]  <= buf_z[1];
      buf_to[0] <= buf_to[1];
    end
    if (push && (count == 2'd1) && !pop) begin
      buf_z[1]  <= push_z;
      buf_to[1] <= push_to;
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_z     = out_valid ? buf_z[0] : '0;
  assign out_to    = out_valid ? buf_to[0] : 1'b0;

endmodule

// File: tb/tb_mul_job_seq.sv
// Self-checking bench for mul_job_seq: behavioural multiplier model plus a result queue
// built from the host-side view of each accepted job.
module tb_mul_job_seq;

  localparam int WIDTH     = 32;
  localparam int TO_CYCLES = 200;
  localparam int TO_W      = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b, op_a, op_b;
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_z;
  logic             out_valid, out_ready, out_to, busy;
  logic [WIDTH-1:0] out_z;

  int vectors = 0;
  int errs    = 0;

  // multiplier model
  logic             mdl_done;
  logic [WIDTH-1:0] mdl_z;
  logic             stale_done = 1'b0;
  int               cd;
  int               lat  = 10;
  bit               hang = 1'b0;
  int               starts = 0;

  logic [32:0] exp_q [$];

  mul_job_seq #(.WIDTH(WIDTH), .TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_a(op_a), .op_b(op_b), .mul_start(mul_start),
    .mul_done(mul_done), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_to(out_to),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign mul_done = mdl_done || stale_done;
  assign mul_z    = mdl_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd       <= 0;
      mdl_done <= 1'b0;
    end else begin
      if (mul_start) starts <= starts + 1;
      if (mul_start && !hang) begin
        cd    <= lat;
        mdl_z <= op_a * op_b;
      end else if (cd > 0) begin
        cd <= cd - 1;
      end
      mdl_done <= (cd == 1);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one clock; any head consumed at the coming edge is compared with the reference queue
  task automatic tick();
    logic [32:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("res_z", 64'(out_z), 64'(e[31:0]));
        check("res_to", 64'(out_to), 64'(e[32]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [32:0] expect_of(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (a == 0 || b == 0) return 33'd0;
    if (hang) return {1'b1, 32'd0};
    return {1'b0, p[31:0]};
  endfunction

  task automatic submit(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 2000) begin tick(); n++; end
    check("accept_timeout", 64'(in_ready), 64'd1);
    if (in_ready) begin
      exp_q.push_back(expect_of(a, b));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 100) begin tick(); n++; end
    out_ready = 1'b0;
    check("drained_empty", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, s0;
    logic pd;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_z", 64'(out_z), 64'd0);
    check("rst_out_to", 64'(out_to), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_op_a", 64'(op_a), 64'd0);
    check("rst_op_b", 64'(op_b), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // 7 x 6 with a 40-cycle multiply
    lat = 40; s0 = starts;
    submit(32'd7, 32'd6);
    check("t1_start_pulse", 64'(mul_start), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_start_drop", 64'(mul_start), 64'd0);
    n = 0; pd = 1'b0;
    while (!out_valid && n < 200) begin pd = mul_done; tick(); n++; end
    check("t1_valid_after_done", 64'(pd), 64'd1);
    check("t1_out_z", 64'(out_z), 64'd42);
    check("t1_out_to", 64'(out_to), 64'd0);
    check("t1_start_count", 64'(starts - s0), 64'd1);
    drain();

    // zero-operand bypass
    s0 = starts;
    submit(32'd0, 32'h1234);
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_out_z", 64'(out_z), 64'd0);
    check("t2_out_to", 64'(out_to), 64'd0);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_no_start", 64'(starts - s0), 64'd0);
    drain();

    // hung multiplier -> watchdog
    hang = 1'b1;
    ra = $urandom | 32'd1; rb = $urandom | 32'd1;
    submit(ra, rb);
    n = 0;
    while (!out_valid && n < 1000) begin tick(); n++; end
    check("t3_timeout_latency", 64'(n), 64'(TO_CYCLES + 1));
    check("t3_out_z", 64'(out_z), 64'd0);
    check("t3_out_to", 64'(out_to), 64'd1);
    check("t3_in_ready", 64'(in_ready), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    drain();
    hang = 1'b0;

    // back-pressure with a full buffer
    lat = 7;
    submit(32'd3, 32'd5); wait_idle();
    submit(32'd4, 32'd4); wait_idle();
    in_a = 32'd2; in_b = 32'd9; in_valid = 1'b1;
    repeat (5) tick();
    check("t4_full_in_ready", 64'(in_ready), 64'd0);
    check("t4_head", 64'(out_z), 64'd15);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("t4_ready_after_pop", 64'(in_ready), 64'd1);
    exp_q.push_back(expect_of(32'd2, 32'd9));
    tick();
    in_valid = 1'b0;
    check("t4_third_busy", 64'(busy), 64'd1);
    wait_idle();
    drain();

    // reset in the middle of WAIT, then a stale done
    lat = 60; s0 = starts;
    submit($urandom | 32'd1, $urandom | 32'd1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_op_a", 64'(op_a), 64'd0);
    check("t5_rst_start", 64'(mul_start), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    stale_done = 1'b1;
    tick(); tick();
    stale_done = 1'b0;
    tick();
    check("t5_stale_no_result", 64'(out_valid), 64'd0);
    check("t5_stale_busy", 64'(busy), 64'd0);
    lat = 12;
    submit($urandom | 32'd1, $urandom | 32'd1);
    wait_idle();
    check("t5_next_job_valid", 64'(out_valid), 64'd1);
    drain();

    // continuous out_ready: push coinciding with pop at count 1
    out_ready = 1'b1;
    lat = 5;
    submit(32'd9, 32'd11);
    wait_idle();
    check("t6_head_99", 64'(out_z), 64'd99);
    submit(32'd0, 32'd77);
    check("t6_coincide_valid", 64'(out_valid), 64'd1);
    check("t6_coincide_z", 64'(out_z), 64'd0);
    tick();
    check("t6_no_dup", 64'(out_valid), 64'd0);
    for (int i = 0; i < 12; i++) begin
      lat = $urandom_range(1, 20);
      ra = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      submit(ra, rb);
      wait_idle();
    end
    drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
